uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: number of consecutive idle cycles of the owning requester before its grant is revoked (legal range 2..65535).
REQ-002 SHALL have port clk  input  1  system clock; one clock for the whole block.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req0_data  input  8  requester 0 byte.
REQ-005 SHALL have port req0_valid  input  1  requester 0 byte valid.
REQ-006 SHALL have port req0_last  input  1  byte is the final byte of requester 0's packet.
REQ-007 SHALL have port req0_ready  output  1  requester 0 byte accepted.
REQ-008 SHALL have ports req1_data, req1_valid, req1_last, req1_ready, identical to REQ-004..007, for requester 1.
REQ-009 SHALL have port tx_data  output  8  byte to the UART transmitter.
REQ-010 SHALL have port tx_valid  output  1  tx_data valid.
REQ-011 SHALL have port tx_ready  input  1  UART transmitter accepts the byte.
REQ-012 SHALL have port grant  output  2  one-hot current owner; 2'b00 when idle.
REQ-013 SHALL have port timeout_pulse  output  1  one-cycle pulse on grant revocation by timeout.

Function
REQ-014 SHALL implement FSM states IDLE, OWN0, OWN1.
REQ-015 A transfer SHALL be the cycle in which tx_valid and tx_ready are both 1.
REQ-016 In IDLE: tx_valid=0, req0_ready=req1_ready=0, grant=00.
REQ-017 In OWNn: tx_data=reqn_data, tx_valid=reqn_valid, reqn_ready=tx_ready, other requester's ready=0, grant bit n=1; all combinational, zero latency.
REQ-018 IDLE with only reqn_valid=1 SHALL go to OWNn next cycle; arbitration latency is exactly 1 cycle.
REQ-019 IDLE with both valid SHALL go to OWN of the requester that is not last_owner (round-robin).
REQ-020 IDLE with neither valid SHALL stay in IDLE.
REQ-021 OWNn with a transfer where reqn_last=1 SHALL go to IDLE next cycle and set last_owner=n.
REQ-022 Packets SHALL be atomic: no byte of the other requester is forwarded between the first and the last byte of an owned packet, except after a timeout.
REQ-023 A 16-bit idle counter SHALL increment on each OWNn cycle with reqn_valid=0 and clear on any cycle with reqn_valid=1 and on any state change.
REQ-024 Cycles where reqn_valid=1 and tx_ready=0 (backpressure) SHALL NOT count toward timeout.
REQ-025 When the idle counter reaches TIMEOUT_CYCLES-1 while reqn_valid=0, the FSM SHALL go to IDLE next cycle, set last_owner=n, and assert timeout_pulse for exactly that next cycle.
REQ-026 A transfer with last=1 in the same cycle the timeout threshold is reached SHALL take priority: normal release, no timeout_pulse.
REQ-027 The IDLE cycle after a release SHALL always occur (no direct OWN0->OWN1 handoff).
REQ-028 The block SHALL not buffer, drop, or duplicate bytes; each transfer forwards exactly one requester byte.

Reset
REQ-029 While reset=1 at a clock edge: state=IDLE, last_owner=1 (requester 0 wins the first tie), idle counter=0, timeout_pulse=0.
REQ-030 Outputs during and immediately after reset: tx_valid=0, req0_ready=0, req1_ready=0, grant=00, timeout_pulse=0; tx_data is don't-care.
REQ-031 Reset asserted mid-packet SHALL abandon the packet; after release, arbitration restarts per REQ-018/019.

Verification
REQ-032 Single requester: req0 sends 0x11,0x22,0x33 (last on 0x33), tx_ready=1 -> grant=01 one cycle after req0_valid; tx bytes 11,22,33 on consecutive cycles; IDLE the following cycle.
REQ-033 Tie after reset: both valid, 2-byte packets 0xA0/0xA1 and 0xB0/0xB1 -> output A0,A1, one IDLE cycle, then B0,B1; grant 01, 00, 10.
REQ-034 Fairness: both requesters continuously send 1-byte packets -> grant alternates 01,00,10,00,01... with no starvation over 100 packets.
REQ-035 Backpressure: tx_ready=0 for 2000 cycles mid-packet with TIMEOUT_CYCLES=1024 -> no timeout_pulse; packet completes intact once tx_ready=1.
REQ-036 Timeout: req1 owns, drops req1_valid after 1 byte with TIMEOUT_CYCLES=4 -> after 4 idle cycles grant=00, timeout_pulse high exactly 1 cycle; pending req0 granted next cycle.
REQ-037 Reset mid-packet: reset during byte 2 of a 4-byte req0 packet -> outputs zeroed next cycle; with both valid after release, req0 granted first.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter in front of a UART transmitter: round-robin
// between whole packets, with grant revocation when the owner goes quiet.
module uart_tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] req0_data,
  input  logic       req0_valid,
  input  logic       req0_last,
  output logic       req0_ready,
  input  logic [7:0] req1_data,
  input  logic       req1_valid,
  input  logic       req1_last,
  output logic       req1_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] grant,
  output logic       timeout_pulse
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [15:0] IDLE_MAX = 16'(TIMEOUT_CYCLES - 1);

  state_t      state;
  logic        last_owner;
  logic [15:0] idle_cnt;
  logic        own_valid;
  logic        own_last;
  logic        xfer;
  logic        timeout_hit;

  // Datapath is a pure mux on the owner; no byte is ever held here.
  always_comb begin
    own_valid = 1'b0;
    own_last  = 1'b0;
    case (state)
      OWN0: begin own_valid = req0_valid; own_last = req0_last; end
      OWN1: begin own_valid = req1_valid; own_last = req1_last; end
      default: ;
    endcase
  end

  assign tx_data     = (state == OWN1) ? req1_data : req0_data;
  assign tx_valid    = own_valid;
  assign req0_ready  = (state == OWN0) && tx_ready;
  assign req1_ready  = (state == OWN1) && tx_ready;
  assign grant       = {state == OWN1, state == OWN0};
  assign xfer        = tx_valid && tx_ready;
  // Only cycles with the owner's valid low count; a stalled valid byte never times out.
  assign timeout_hit = (state != IDLE) && !own_valid && (idle_cnt == IDLE_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        IDLE: begin
          idle_cnt <= '0;
          if (req0_valid && (!req1_valid || last_owner)) state <= OWN0;
          else if (req1_valid)                           state <= OWN1;
        end
        default: begin
          if (xfer && own_last) begin
            state      <= IDLE;
            last_owner <= (state == OWN1);
            idle_cnt   <= '0;
          end else if (own_valid) begin
            idle_cnt <= '0;
          end else if (timeout_hit) begin
            state         <= IDLE;
            last_owner    <= (state == OWN1);
            idle_cnt      <= '0;
            timeout_pulse <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + 16'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: one instance at the default timeout,
// one at TIMEOUT_CYCLES=4, both driven from the same stimulus.
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req0_last, req1_valid, req1_last;
  logic       tx_ready;

  logic       req0_ready, req1_ready, tx_valid, timeout_pulse;
  logic [7:0] tx_data;
  logic [1:0] grant;

  logic       t_req0_ready, t_req1_ready, t_tx_valid, t_timeout_pulse;
  logic [7:0] t_tx_data;
  logic [1:0] t_grant;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(req1_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant(grant), .timeout_pulse(timeout_pulse)
  );

  uart_tx_arbiter #(.TIMEOUT_CYCLES(4)) dut_t (
    .clk(clk), .reset(reset),
    .req0_data(req0_data), .req0_valid(req0_valid), .req0_last(req0_last), .req0_ready(t_req0_ready),
    .req1_data(req1_data), .req1_valid(req1_valid), .req1_last(req1_last), .req1_ready(t_req1_ready),
    .tx_data(t_tx_data), .tx_valid(t_tx_valid), .tx_ready(tx_ready),
    .grant(t_grant), .timeout_pulse(t_timeout_pulse)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen 2 units after.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    logic       any_pulse;
    logic [1:0] exp_g;

    reset = 1'b1;
    req0_data = 8'h00; req0_valid = 1'b0; req0_last = 1'b0;
    req1_data = 8'h00; req1_valid = 1'b0; req1_last = 1'b0;
    tx_ready = 1'b1;
    step(); step();
    settle();
    chk("rst_grant", 16'(grant), 16'h0);
    chk("rst_txv", 16'(tx_valid), 16'h0);
    chk("rst_rdy", 16'({req0_ready, req1_ready}), 16'h0);
    chk("rst_pulse", 16'(timeout_pulse), 16'h0);
    reset = 1'b0;

    // Single requester, 3-byte packet
    req0_valid = 1'b1; req0_data = 8'h11;
    settle();
    chk("single_arb_lat", 16'(grant), 16'h0);
    step(); settle();
    chk("single_grant", 16'(grant), 16'h1);
    chk("single_b0", 16'({tx_valid, tx_data}), 16'h111);
    chk("single_rdy", 16'({req0_ready, req1_ready}), 16'h2);
    step(); req0_data = 8'h22; settle();
    chk("single_b1", 16'({tx_valid, tx_data}), 16'h122);
    step(); req0_data = 8'h33; req0_last = 1'b1; settle();
    chk("single_b2", 16'({tx_valid, tx_data}), 16'h133);
    step(); req0_valid = 1'b0; req0_last = 1'b0; settle();
    chk("single_release", 16'(grant), 16'h0);
    chk("single_txv_idle", 16'(tx_valid), 16'h0);

    // Tie right after reset: requester 0 first
    reset = 1'b1; step(); reset = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hA0;
    req1_valid = 1'b1; req1_data = 8'hB0;
    step(); settle();
    chk("tie_grant0", 16'(grant), 16'h1);
    chk("tie_a0", 16'(tx_data), 16'hA0);
    step(); req0_data = 8'hA1; req0_last = 1'b1; settle();
    chk("tie_a1", 16'(tx_data), 16'hA1);
    step(); req0_valid = 1'b0; req0_last = 1'b0; settle();
    chk("tie_gap_grant", 16'(grant), 16'h0);
    chk("tie_gap_rdy", 16'({tx_valid, req0_ready, req1_ready}), 16'h0);
    step(); settle();
    chk("tie_grant1", 16'(grant), 16'h2);
    chk("tie_b0", 16'(tx_data), 16'hB0);
    chk("tie_rdy1", 16'({req0_ready, req1_ready}), 16'h1);
    step(); req1_data = 8'hB1; req1_last = 1'b1; settle();
    chk("tie_b1", 16'(tx_data), 16'hB1);
    step(); req1_valid = 1'b0; req1_last = 1'b0; settle();
    chk("tie_end", 16'(grant), 16'h0);

    // Fairness: last owner was requester 1, so requester 0 goes next
    req0_valid = 1'b1; req0_last = 1'b1; req0_data = 8'h5A;
    req1_valid = 1'b1; req1_last = 1'b1; req1_data = 8'hC3;
    exp_g = 2'b01;
    for (int p = 0; p < 100; p++) begin
      step(); settle();
      chk("fair_grant", 16'(grant), 16'(exp_g));
      chk("fair_data", 16'(tx_data), (exp_g == 2'b01) ? 16'h5A : 16'hC3);
      step(); settle();
      chk("fair_gap", 16'(grant), 16'h0);
      exp_g = {exp_g[0], exp_g[1]};
    end
    req0_valid = 1'b0; req0_last = 1'b0;
    req1_valid = 1'b0; req1_last = 1'b0;
    step();

    // Backpressure for 2000 cycles mid-packet never times out
    req0_valid = 1'b1; req0_data = 8'h01;
    step(); settle();
    chk("bp_grant", 16'(grant), 16'h1);
    step(); req0_data = 8'h02; tx_ready = 1'b0;
    any_pulse = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      step();
      any_pulse = any_pulse | timeout_pulse | t_timeout_pulse;
    end
    settle();
    chk("bp_no_pulse", 16'(any_pulse), 16'h0);
    chk("bp_still_owned", 16'(grant), 16'h1);
    chk("bp_rdy_low", 16'({tx_valid, req0_ready}), 16'h2);
    tx_ready = 1'b1; settle();
    chk("bp_b1", 16'({tx_valid, tx_data}), 16'h102);
    step(); req0_data = 8'h03; req0_last = 1'b1; settle();
    chk("bp_b2", 16'(tx_data), 16'h03);
    step(); req0_valid = 1'b0; req0_last = 1'b0; settle();
    chk("bp_end", 16'(grant), 16'h0);

    // Timeout on the TIMEOUT_CYCLES=4 instance
    req1_valid = 1'b1; req1_data = 8'h77;
    step(); settle();
    chk("to_grant1", 16'(t_grant), 16'h2);
    step(); req1_valid = 1'b0; req0_valid = 1'b1; req0_data = 8'h99;
    for (int c = 0; c < 3; c++) begin
      step(); settle();
      chk("to_wait_grant", 16'(t_grant), 16'h2);
      chk("to_wait_pulse", 16'(t_timeout_pulse), 16'h0);
    end
    step(); settle();
    chk("to_revoke_grant", 16'(t_grant), 16'h0);
    chk("to_pulse", 16'(t_timeout_pulse), 16'h1);
    step(); settle();
    chk("to_next_grant", 16'(t_grant), 16'h1);
    chk("to_pulse_1cyc", 16'(t_timeout_pulse), 16'h0);
    chk("to_next_data", 16'(t_tx_data), 16'h99);
    req0_valid = 1'b0;

    // Reset in the middle of a 4-byte req0 packet
    reset = 1'b1; step(); reset = 1'b0;
    req0_valid = 1'b1; req0_data = 8'hD0;
    step(); settle();
    chk("mid_grant", 16'(grant), 16'h1);
    step(); req0_data = 8'hD1; reset = 1'b1;
    req1_valid = 1'b1; req1_data = 8'hE0;
    step(); settle();
    chk("mid_rst_out", 16'({grant, tx_valid, req0_ready, req1_ready, timeout_pulse}), 16'h0);
    reset = 1'b0; settle();
    chk("mid_post_idle", 16'(grant), 16'h0);
    step(); settle();
    chk("mid_rearb", 16'(grant), 16'h1);
    chk("mid_rearb_data", 16'(tx_data), 16'hD1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
